// File: rtl/fetch_ctrl_pkg.sv
// Shared widths and enable levels for the instruction fetch controller.
package fetch_ctrl_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Byte distance between the two instructions of a pair, and between pairs.
    localparam logic [ADDR_W-1:0] INST_STEP = 32'd4;
    localparam logic [ADDR_W-1:0] PAIR_STEP = 32'd8;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: fetches two consecutive instructions from the
// instruction cache, one request at a time, and pushes them as a pair into the
// instruction queue. A redirect (clear) discards any partial pair and restarts
// fetch at the redirect target, draining an outstanding cache response first.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | after reset, waiting for the first ready cycle
// FETCH_O   | request outstanding for the first instruction (addr = pc)
// FETCH_T   | request outstanding for the second instruction (addr = pc+4)
// PUSH      | pair captured, waiting for queue space
// DRAIN     | redirect pending, waiting to discard an in-flight response
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic [ADDR_W-1:0] jumpAddr,
    input  logic              ifStall,
    output logic              icReq,
    output logic [ADDR_W-1:0] icAddr,
    input  logic              icValid,
    input  logic [INST_W-1:0] icInst,
    output logic              instEnO,
    output logic              instEnT,
    output logic [INST_W-1:0] instO,
    output logic [INST_W-1:0] instT,
    output logic [ADDR_W-1:0] PCO,
    output logic [ADDR_W-1:0] PCT
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_O = 3'd1,
        S_FETCH_T = 3'd2,
        S_PUSH    = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] slot_o;
    logic [INST_W-1:0] slot_t;

    // Fetch sequencing, redirect handling and all registered outputs.
    // Outputs are computed alongside the next state so icReq/icAddr are
    // already valid in the first cycle of FETCH_O/FETCH_T.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            slot_o  <= '0;
            slot_t  <= '0;
            icReq   <= DISABLE;
            icAddr  <= RESET_PC;
            instEnO <= DISABLE;
            instEnT <= DISABLE;
            instO   <= '0;
            instT   <= '0;
            PCO     <= '0;
            PCT     <= '0;
        end else if (rdy) begin
            instEnO <= DISABLE;
            instEnT <= DISABLE;
            if (clear) begin
                pc <= jumpAddr;
                case (state)
                    S_FETCH_O, S_FETCH_T, S_DRAIN: begin
                        // A response arriving with the redirect closes the
                        // outstanding request, so fetch can restart at once.
                        if (icValid) begin
                            state  <= S_FETCH_O;
                            icReq  <= ENABLE;
                            icAddr <= jumpAddr;
                        end else begin
                            state <= S_DRAIN;
                            icReq <= DISABLE;
                        end
                    end
                    default: begin
                        state  <= S_FETCH_O;
                        icReq  <= ENABLE;
                        icAddr <= jumpAddr;
                    end
                endcase
            end else begin
                case (state)
                    S_IDLE: begin
                        state  <= S_FETCH_O;
                        icReq  <= ENABLE;
                        icAddr <= pc;
                    end
                    S_FETCH_O: begin
                        if (icValid) begin
                            slot_o <= icInst;
                            state  <= S_FETCH_T;
                            icAddr <= pc + INST_STEP;
                        end
                    end
                    S_FETCH_T: begin
                        if (icValid) begin
                            slot_t <= icInst;
                            state  <= S_PUSH;
                            icReq  <= DISABLE;
                        end
                    end
                    S_PUSH: begin
                        if (!ifStall) begin
                            instEnO <= ENABLE;
                            instEnT <= ENABLE;
                            instO   <= slot_o;
                            instT   <= slot_t;
                            PCO     <= pc;
                            PCT     <= pc + INST_STEP;
                            pc      <= pc + PAIR_STEP;
                            state   <= S_FETCH_O;
                            icReq   <= ENABLE;
                            icAddr  <= pc + PAIR_STEP;
                        end
                    end
                    S_DRAIN: begin
                        if (icValid) begin
                            state  <= S_FETCH_O;
                            icReq  <= ENABLE;
                            icAddr <= pc;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        icReq <= DISABLE;
                    end
                endcase
            end
        end
    end

endmodule
